// File: rtl/tlb_ptw.sv
// tlb_ptw: two-level page-table walker behind the TLB's PTW port.
// It takes one missing virtual address at a time and reads up to two PTEs from
// memory. It returns the leaf PTE, or 32'd0 on any structural fault or timeout.
// A level-1 leaf is returned as a 4 KiB-granular PTE by splicing in vaddr[21:12].
module tlb_ptw #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter bit          SUPERPAGE_EN   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [19:0] satp_ppn_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] vaddr_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] pte_o,
   output logic        mem_req_valid_o,
   input  logic        mem_req_ready_i,
   output logic [31:0] mem_addr_o,
   input  logic        mem_resp_valid_i,
   output logic        mem_resp_ready_o,
   input  logic [31:0] mem_rdata_i
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_L1_REQ  = 3'd1;
   localparam logic [2:0] S_L1_WAIT = 3'd2;
   localparam logic [2:0] S_L0_REQ  = 3'd3;
   localparam logic [2:0] S_L0_WAIT = 3'd4;
   localparam logic [2:0] S_RESP    = 3'd5;

   logic [2:0]       r_state;
   logic [19:0]      r_vpn;    // vaddr[31:12]; the page offset is never needed
   logic [19:0]      r_base;   // PPN of the table being read at the current level
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_pte;

   logic             w_pte_v;
   logic             w_pte_leaf;
   logic             w_sp_ok;
   logic [31:0]      w_sp_pte;
   logic             w_timeout;
   logic             w_unused;

   // The page offset of the request plays no part in the walk.
   assign w_unused   = &{1'b0, vaddr_i[11:0]};

   // Decode of the PTE arriving from memory.
   assign w_pte_v    = mem_rdata_i[0];
   assign w_pte_leaf = mem_rdata_i[1] | mem_rdata_i[2];
   assign w_sp_ok    = SUPERPAGE_EN && (mem_rdata_i[21:12] == 10'd0);
   assign w_sp_pte   = {mem_rdata_i[31:22], r_vpn[9:0], mem_rdata_i[11:0]};
   assign w_timeout  = (r_cnt == CNT_LAST);

   // Handshake outputs are pure functions of the state, so an asynchronous
   // reset drops them immediately and no input feeds an output combinationally.
   assign req_ready_o      = (r_state == S_IDLE);
   assign resp_valid_o     = (r_state == S_RESP);
   assign pte_o            = r_pte;
   assign mem_req_valid_o  = (r_state == S_L1_REQ) || (r_state == S_L0_REQ);
   assign mem_resp_ready_o = (r_state == S_L1_WAIT) || (r_state == S_L0_WAIT);
   assign mem_addr_o       = (r_state == S_L1_REQ) ? {r_base, r_vpn[19:10], 2'b00} :
                             (r_state == S_L0_REQ) ? {r_base, r_vpn[9:0],  2'b00} :
                                                     32'd0;

   // Walk sequencing: latch the request, issue/await each level, evaluate the PTE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_vpn   <= '0;
         r_base  <= '0;
         r_cnt   <= '0;
         r_pte   <= '0;
      end else begin
         // NOTE: every register here uses <= so each branch sees the values from
         // before this edge, regardless of statement order.
         case (r_state)
            S_IDLE: begin
               if (req_valid_i) begin
                  r_vpn   <= vaddr_i[31:12];
                  r_base  <= satp_ppn_i;
                  r_pte   <= '0;
                  r_state <= S_L1_REQ;
               end
            end
            S_L1_REQ: begin
               if (mem_req_ready_i) begin
                  r_cnt   <= '0;
                  r_state <= S_L1_WAIT;
               end
            end
            S_L1_WAIT: begin
               if (mem_resp_valid_i) begin
                  r_cnt <= '0;
                  if (!w_pte_v) begin
                     r_pte   <= '0;
                     r_state <= S_RESP;
                  end else if (!w_pte_leaf) begin
                     r_base  <= mem_rdata_i[31:12];
                     r_state <= S_L0_REQ;
                  end else begin
                     r_pte   <= w_sp_ok ? w_sp_pte : 32'd0;
                     r_state <= S_RESP;
                  end
               end else if (w_timeout) begin
                  r_cnt   <= '0;
                  r_pte   <= '0;
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_L0_REQ: begin
               if (mem_req_ready_i) begin
                  r_cnt   <= '0;
                  r_state <= S_L0_WAIT;
               end
            end
            S_L0_WAIT: begin
               if (mem_resp_valid_i) begin
                  r_cnt   <= '0;
                  // A pointer at the last level is as much a fault as V=0.
                  r_pte   <= (w_pte_v && w_pte_leaf) ? mem_rdata_i : 32'd0;
                  r_state <= S_RESP;
               end else if (w_timeout) begin
                  r_cnt   <= '0;
                  r_pte   <= '0;
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RESP: begin
               if (resp_ready_i) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
